// File: rtl/lcd_row_arbiter.sv
// Round-robin arbiter sharing one 16x2 LCD among N_CLIENTS, with a minimum display hold per owner.
// Optional `define LCD_ARB_PRIORITY_EN: client 0 takes the display from any other owner at once.
module lcd_row_arbiter #(
  parameter int N_CLIENTS   = 3,
  parameter int HOLD_CYCLES = 200,
  parameter int CNT_W       = 16,
  localparam int ID_W       = $clog2(N_CLIENTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CLIENTS-1:0]     req,
  input  logic [N_CLIENTS*128-1:0] row1_in,
  input  logic [N_CLIENTS*128-1:0] row2_in,
  output logic [N_CLIENTS-1:0]     grant,
  output logic [ID_W-1:0]          owner_id,
  output logic                     busy,
  output logic                     update,
  output logic [127:0]             row_1,
  output logic [127:0]             row_2
);

  localparam logic [127:0] BLANK = {16{8'h20}};

  typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

  state_t             state, state_nx;
  logic [N_CLIENTS-1:0] grant_nx;
  logic [ID_W-1:0]    owner_nx, rr_ptr, ptr_nx, win;
  logic               busy_nx, update_nx, do_grant, go_idle;
  logic [127:0]       row1_nx, row2_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               hold_met, others, urgent;
  logic [ID_W:0]      pick;
  logic [N_CLIENTS-1:0] own_mask;

  // Returns {found, index} of the first requester at or after 'from', wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [N_CLIENTS-1:0] r,
                                            input logic [ID_W-1:0] from);
    logic [ID_W:0] res;
    logic [ID_W:0] idx;
    res = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      idx = {1'b0, from} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_CLIENTS)) idx = idx - (ID_W+1)'(N_CLIENTS);
      if (r[idx[ID_W-1:0]]) res = {1'b1, idx[ID_W-1:0]};
    end
    return res;
  endfunction

  assign hold_met = (cnt >= CNT_W'(HOLD_CYCLES));
  assign own_mask = N_CLIENTS'(1) << owner_id;
  assign others   = |(req & ~own_mask);
  assign pick     = rr_pick(req, rr_ptr);

`ifdef LCD_ARB_PRIORITY_EN
  assign urgent = req[0] && (state != IDLE) && (owner_id != '0);
`else
  assign urgent = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    owner_nx  = owner_id;
    busy_nx   = busy;
    update_nx = 1'b0;
    row1_nx   = row_1;
    row2_nx   = row_2;
    cnt_nx    = cnt;
    ptr_nx    = rr_ptr;
    do_grant  = 1'b0;
    go_idle   = 1'b0;
    win       = '0;

    if (state != IDLE && !hold_met) cnt_nx = cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (pick[ID_W]) begin
          do_grant = 1'b1;
          win      = pick[ID_W-1:0];
        end
      end
      OWN: begin
        if (urgent) begin
          do_grant = 1'b1;
        end else if (!req[owner_id] && !hold_met) begin
          state_nx = LINGER;
          grant_nx = '0;
        end else if (hold_met && (!req[owner_id] || others)) begin
          do_grant = pick[ID_W];
          go_idle  = !pick[ID_W];
          win      = pick[ID_W-1:0];
        end else begin
          // Owner keeps the display; its text is tracked live.
          row1_nx = row1_in[{owner_id, 7'd0} +: 128];
          row2_nx = row2_in[{owner_id, 7'd0} +: 128];
        end
      end
      LINGER: begin
        if (urgent) begin
          do_grant = 1'b1;
        end else if (hold_met) begin
          do_grant = pick[ID_W];
          go_idle  = !pick[ID_W];
          win      = pick[ID_W-1:0];
        end
      end
      default: state_nx = IDLE;
    endcase

    if (do_grant) begin
      state_nx  = OWN;
      grant_nx  = N_CLIENTS'(1) << win;
      owner_nx  = win;
      busy_nx   = 1'b1;
      update_nx = 1'b1;
      row1_nx   = row1_in[{win, 7'd0} +: 128];
      row2_nx   = row2_in[{win, 7'd0} +: 128];
      cnt_nx    = '0;
      ptr_nx    = (win == ID_W'(N_CLIENTS - 1)) ? '0 : win + ID_W'(1);
    end else if (go_idle) begin
      state_nx  = IDLE;
      grant_nx  = '0;
      busy_nx   = 1'b0;
      update_nx = 1'b1;
      row1_nx   = BLANK;
      row2_nx   = BLANK;
      cnt_nx    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      busy     <= 1'b0;
      update   <= 1'b0;
      row_1    <= BLANK;
      row_2    <= BLANK;
      cnt      <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      owner_id <= owner_nx;
      busy     <= busy_nx;
      update   <= update_nx;
      row_1    <= row1_nx;
      row_2    <= row2_nx;
      cnt      <= cnt_nx;
      rr_ptr   <= ptr_nx;
    end
  end

endmodule

// File: tb/tb_lcd_row_arbiter.sv
// Bench for lcd_row_arbiter: directed scenarios, an abstract per-cycle model, and literal spot checks.
`timescale 1ms/1us
module tb_lcd_row_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam logic [127:0] BLANK = {16{8'h20}};
`ifdef LCD_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*128-1:0] row1_in, row2_in;
  logic [N-1:0]   grant;
  logic [1:0]     owner_id;
  logic           busy, update;
  logic [127:0]   row_1, row_2;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_row_arbiter #(.N_CLIENTS(N), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .row1_in(row1_in), .row2_in(row2_in),
    .grant(grant), .owner_id(owner_id), .busy(busy), .update(update),
    .row_1(row_1), .row_2(row_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
  endtask

  // Abstract model: who shows text, whether it is live or frozen, how long it has been shown.
  bit           armed = 1'b0;
  int           m_owner, m_shown, m_next;
  bit           m_showing, m_live, m_upd;
  logic [127:0] m_r1, m_r2;

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    bit held, others_req, to_blank;
    int win;
    if (rst) begin
      m_owner = 0; m_shown = 0; m_next = 0;
      m_showing = 0; m_live = 0; m_upd = 0;
      m_r1 = BLANK; m_r2 = BLANK;
      armed = 1'b1;
    end else begin
      held       = (m_shown >= HOLD);
      others_req = (req & ~(3'b001 << m_owner)) != 3'b000;
      win        = -1;
      to_blank   = 0;
      m_upd      = 0;
      if (!m_showing) win = rr_pick(req, m_next);
      else if (PRIO && req[0] && m_owner != 0) win = 0;
      else if (m_live && req[m_owner] && !(held && others_req)) ;
      else if (m_live && !req[m_owner] && !held) m_live = 0;
      else if (held) begin
        win = rr_pick(req, m_next);
        if (win < 0) to_blank = 1;
      end
      if (m_showing) m_shown = (m_shown + 1 > HOLD) ? HOLD : m_shown + 1;
      if (win >= 0) begin
        m_owner = win; m_showing = 1; m_live = 1; m_shown = 0;
        m_next = (win + 1) % N; m_upd = 1;
      end else if (to_blank) begin
        m_showing = 0; m_live = 0; m_upd = 1;
        m_r1 = BLANK; m_r2 = BLANK;
      end
      if (m_live) begin
        m_r1 = row1_in[m_owner*128 +: 128];
        m_r2 = row2_in[m_owner*128 +: 128];
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("grant",    grant,    (m_showing && m_live) ? (3'b001 << m_owner) : 3'b000);
      check("owner_id", owner_id, m_owner);
      check("busy",     busy,     m_showing);
      check("update",   update,   m_upd);
      check("row_1",    row_1,    m_r1);
      check("row_2",    row_2,    m_r2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [2:0]   seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [127:0] live;

  initial begin
    rst = 1'b1;
    req = 3'b111;
    row1_in[0*128 +: 128] = "Client0 text AAA";
    row1_in[1*128 +: 128] = " Hello  Player 1";
    row1_in[2*128 +: 128] = "Client2 text CCC";
    row2_in[0*128 +: 128] = "Line2 client 0  ";
    row2_in[1*128 +: 128] = "Line2 client 1  ";
    row2_in[2*128 +: 128] = "Line2 client 2  ";

    // Reset held with all requests active
    tick(2);
    check("rst_grant", grant, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_update", update, 1'b0);
    check("rst_row_1", row_1, BLANK);
    check("rst_row_2", row_2, BLANK);
    rst = 1'b0;
    tick(1);
    check("first_grant", grant, 3'b001);

    // Single client, released early: linger then blank
    rst = 1'b1; req = 3'b000; tick(1);
    rst = 1'b0; req = 3'b010; tick(1);
    check("single_grant", grant, 3'b010);
    check("single_owner", owner_id, 2'd1);
    check("single_update", update, 1'b1);
    check("single_row_1", row_1, " Hello  Player 1");
    tick(1);
    req = 3'b000;
    tick(1);
    row1_in[1*128 +: 128] = "Client1 text BBB";
    check("linger_grant", grant, 3'b000);
    check("linger_busy", busy, 1'b1);
    check("linger_row_1_a", row_1, " Hello  Player 1");
    tick(1);
    check("linger_row_1_b", row_1, " Hello  Player 1");
    tick(1);
    check("linger_row_1_c", row_1, " Hello  Player 1");
    check("linger_update", update, 1'b0);
    tick(1);
    check("idle_row_1", row_1, BLANK);
    check("idle_update", update, 1'b1);
    check("idle_busy", busy, 1'b0);
    tick(1);
    check("idle_update_off", update, 1'b0);

    // Contention from reset order
    rst = 1'b1; tick(1);
    rst = 1'b0; req = 3'b111; tick(1);
    for (int g = 0; g < 4; g++) begin
      check("rr_grant_first", grant, seq[g]);
      check("rr_update_first", update, 1'b1);
      for (int c = 0; c < HOLD; c++) begin
        tick(1);
        check("rr_grant_hold", grant, seq[g]);
        check("rr_update_hold", update, 1'b0);
      end
      if (g < 3) tick(1);
    end

    // Live text from the owner, no update pulse
    req = 3'b001;
    for (int i = 0; i < 6; i++) begin
      live = {16{8'h30 + 8'(i)}};
      row2_in[0*128 +: 128] = live;
      tick(1);
      check("live_row_2", row_2, live);
      check("live_update", update, 1'b0);
      check("live_grant", grant, 3'b001);
    end

    // Release after hold is met: straight to blank
    req = 3'b000;
    tick(1);
    check("release_grant", grant, 3'b000);
    check("release_busy", busy, 1'b0);
    check("release_update", update, 1'b1);
    check("release_row_1", row_1, BLANK);

    // Reset during linger
    rst = 1'b1; tick(1);
    rst = 1'b0; req = 3'b010; tick(2);
    req = 3'b000; tick(1);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; tick(1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_row_1", row_1, BLANK);
    check("mid_rst_update", update, 1'b0);
    check("mid_rst_owner", owner_id, 2'd0);
    rst = 1'b0; req = 3'b110; tick(1);
    check("mid_rst_rrptr", grant, 3'b010);

    // Client 0 asks while client 2 owns
    rst = 1'b1; req = 3'b000; tick(1);
    rst = 1'b0; req = 3'b100; tick(2);
    req = 3'b101; tick(1);
`ifdef LCD_ARB_PRIORITY_EN
    check("prio_grant", grant, 3'b001);
    check("prio_update", update, 1'b1);
`else
    check("noprio_grant_a", grant, 3'b100);
    check("noprio_update", update, 1'b0);
    tick(2);
    check("noprio_grant_b", grant, 3'b100);
    tick(1);
    check("noprio_grant_c", grant, 3'b001);
    check("noprio_update_c", update, 1'b1);
`endif
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
